// File: rtl/signed_mul_pkg.sv
// Shared definitions for the signed/unsigned serial multiplier.
//   state_t  : control FSM states (IDLE, LOAD, MULT, SIGN)
//   NEG_W    : widest vector twos_neg() accepts
//   twos_neg : two's complement negation. Callers zero-extend their operand
//              to NEG_W and keep only their own low bits. The low K bits of
//              ~v+1 depend only on the low K bits of v, so one function
//              serves every operand and product width.
package signed_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MULT = 2'd2,
        SIGN = 2'd3
    } state_t;

    localparam int NEG_W = 128;

    function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] v);
        return ~v + NEG_W'(1);
    endfunction

endpackage

// File: rtl/serial_shift_in_p.sv
// Serial-to-parallel operand capture.
// Ports:
//   clk, rst : clock and asynchronous active-low reset
//   bit_in   : serial data, MSB first
//   shift    : one bit is captured per clk while high
//   data     : shift register; the newest bit lands in the LSB
//   full     : one-cycle pulse in the cycle after every WIDTH-th captured bit
// The bit counter wraps, so continued shifting simply starts a new word and
// overwrites the oldest bits.
module serial_shift_in_p #(
    parameter int WIDTH = 12,
    parameter int CNT_W = $clog2(2*WIDTH)+1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             shift,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    logic [CNT_W-1:0] cnt;
    logic             last_bit;

    assign last_bit = (cnt == CNT_W'(WIDTH-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
            cnt  <= '0;
            full <= 1'b0;
        end else begin
            full <= 1'b0;
            if (shift) begin
                data <= {data[WIDTH-2:0], bit_in};
                cnt  <= last_bit ? '0 : cnt + CNT_W'(1);
                full <= last_bit;
            end
        end
    end

endmodule

// File: rtl/signed_serial_multiplier_p.sv
// Serial-in / serial-out shift-add multiplier, two's complement or unsigned.
// Ports:
//   clk, rst         : clock and asynchronous active-low reset
//   x_in, sx, fx     : X serial bit, shift enable, word-captured pulse
//   y_in, sy, fy     : Y serial bit, shift enable, word-captured pulse
//   signed_mode      : 1 = two's complement, 0 = unsigned; sampled with mul
//   mul, busy, done  : start request, operation in flight, product-ready pulse
//   z_par            : 2*WIDTH-bit product, held until the next accepted mul
//   sz, z_out, fz    : result shift enable, serial bit (MSB first), last-bit pulse
//   fsm_state        : current control state, for observation only
// Handshake: mul is accepted only in IDLE. busy rises on the edge that accepts
// it and falls on the edge that raises done. A mul seen while busy is dropped.
// done lasts one cycle, and z_par is valid from that cycle on.
// Sign handling: operands are reduced to magnitudes in LOAD. An unsigned
// magnitude product is built over WIDTH iterations in MULT. SIGN reapplies the
// sign. The magnitude 2^(WIDTH-1) of the most negative operand fits unsigned.
module signed_serial_multiplier_p
    import signed_mul_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int CNT_W = $clog2(2*WIDTH)+1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_in,
    input  logic               sx,
    output logic               fx,
    input  logic               y_in,
    input  logic               sy,
    output logic               fy,
    input  logic               signed_mode,
    input  logic               mul,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] z_par,
    input  logic               sz,
    output logic               z_out,
    output logic               fz,
    output state_t             fsm_state
);

    localparam int PW = 2*WIDTH;

    logic [WIDTH-1:0] x_reg, y_reg;

    serial_shift_in_p #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_shift_x (
        .clk    (clk),
        .rst    (rst),
        .bit_in (x_in),
        .shift  (sx),
        .data   (x_reg),
        .full   (fx)
    );

    serial_shift_in_p #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_shift_y (
        .clk    (clk),
        .rst    (rst),
        .bit_in (y_in),
        .shift  (sy),
        .data   (y_reg),
        .full   (fy)
    );

    state_t           state, state_nxt;
    logic             start, finish, last_iter;
    logic [WIDTH-1:0] xa, ya;          // operands copied when mul is accepted
    logic             sm;              // signed_mode copied when mul is accepted
    logic             res_sign;
    logic [WIDTH-1:0] mcand, mplier;   // magnitudes used by the shift-add loop
    logic [PW-1:0]    acc;
    logic [CNT_W-1:0] iter;
    logic [PW-1:0]    zsr;             // result output shift register
    logic [CNT_W-1:0] zcnt;

    logic [NEG_W-1:0] x_neg_w, y_neg_w, acc_neg_w;
    logic [WIDTH-1:0] x_mag, y_mag;
    logic [PW-1:0]    partial, result;
    logic             unused_neg_bits;

    assign x_neg_w   = twos_neg(NEG_W'(xa));
    assign y_neg_w   = twos_neg(NEG_W'(ya));
    assign acc_neg_w = twos_neg(NEG_W'(acc));
    // Upper bits of the wide negations carry no information for this width.
    assign unused_neg_bits = ^{x_neg_w[NEG_W-1:WIDTH], y_neg_w[NEG_W-1:WIDTH],
                               acc_neg_w[NEG_W-1:PW]};

    assign x_mag   = (sm && xa[WIDTH-1]) ? x_neg_w[WIDTH-1:0] : xa;
    assign y_mag   = (sm && ya[WIDTH-1]) ? y_neg_w[WIDTH-1:0] : ya;
    assign partial = {{WIDTH{1'b0}}, mcand} << iter;
    assign result  = res_sign ? acc_neg_w[PW-1:0] : acc;

    assign fsm_state = state;
    assign z_out     = zsr[PW-1];
    assign fz        = sz && (zcnt == CNT_W'(PW-1));

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next state and control strobes
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        last_iter = (iter == CNT_W'(WIDTH-1));
        case (state)
            IDLE: if (mul) begin
                state_nxt = LOAD;
                start     = 1'b1;
            end
            LOAD: state_nxt = MULT;
            MULT: if (last_iter) state_nxt = SIGN;
            SIGN: begin
                state_nxt = IDLE;
                finish    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, shift-add datapath and result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xa       <= '0;
            ya       <= '0;
            sm       <= 1'b0;
            res_sign <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            iter     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            z_par    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                xa   <= x_reg;
                ya   <= y_reg;
                sm   <= signed_mode;
                busy <= 1'b1;
            end
            if (state == LOAD) begin
                mcand    <= x_mag;
                mplier   <= y_mag;
                res_sign <= sm & (xa[WIDTH-1] ^ ya[WIDTH-1]);
                acc      <= '0;
                iter     <= '0;
            end
            if (state == MULT) begin
                if (mplier[0]) acc <= acc + partial;
                mplier <= mplier >> 1;
                iter   <= iter + CNT_W'(1);
            end
            if (finish) begin
                z_par <= result;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end

    // Output shifter; a reload from SIGN wins over a concurrent shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zsr  <= '0;
            zcnt <= '0;
        end else if (finish) begin
            zsr  <= result;
            zcnt <= '0;
        end else if (sz) begin
            zsr  <= zsr << 1;
            zcnt <= (zcnt == CNT_W'(PW-1)) ? '0 : zcnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_signed_serial_multiplier_p.sv
// Directed bench for signed_serial_multiplier_p at WIDTH=12 with hand-computed products.
module tb_signed_serial_multiplier_p;
    import signed_mul_pkg::*;

    localparam int N  = 12;
    localparam int PW = 2*N;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          x_in = 1'b0, sx = 1'b0, y_in = 1'b0, sy = 1'b0;
    logic          signed_mode = 1'b0, mul = 1'b0, sz = 1'b0;
    logic          fx, fy, busy, done, z_out, fz;
    logic [PW-1:0] z_par;
    state_t        fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    signed_serial_multiplier_p #(.WIDTH(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .x_in        (x_in),
        .sx          (sx),
        .fx          (fx),
        .y_in        (y_in),
        .sy          (sy),
        .fy          (fy),
        .signed_mode (signed_mode),
        .mul         (mul),
        .busy        (busy),
        .done        (done),
        .z_par       (z_par),
        .sz          (sz),
        .z_out       (z_out),
        .fz          (fz),
        .fsm_state   (fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift both operands MSB first; fx/fy must pulse right after the 12th bit.
    task automatic shift_xy(input logic [N-1:0] xv, input logic [N-1:0] yv);
        for (int i = N-1; i >= 0; i--) begin
            sx = 1'b1; sy = 1'b1;
            x_in = xv[i]; y_in = yv[i];
            tick();
            if (i == 1) check("fx_early", PW'(fx), PW'(0));
        end
        sx = 1'b0; sy = 1'b0; x_in = 1'b0; y_in = 1'b0;
        check("fx_pulse", PW'(fx), PW'(1));
        check("fy_pulse", PW'(fy), PW'(1));
        tick();
        check("fx_clear", PW'(fx), PW'(0));
    endtask

    // Request a product, optionally streaming new X bits in while it runs.
    // lat = cycles from the accepting edge to done, 0 on timeout.
    task automatic run_mul(input logic sm, input logic [N-1:0] new_x, input logic shift_during,
                           output int lat);
        signed_mode = sm;
        mul = 1'b1;
        tick();
        mul = 1'b0;
        check("busy_on", PW'(busy), PW'(1));
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (shift_during && c <= N) begin
                sx = 1'b1; x_in = new_x[N-c];
            end else begin
                sx = 1'b0; x_in = 1'b0;
            end
            tick();
            if (done) begin
                lat = c;
                break;
            end
        end
        sx = 1'b0; x_in = 1'b0;
    endtask

    task automatic do_product(input string tag, input logic [N-1:0] xv, input logic [N-1:0] yv,
                              input logic sm, input logic [PW-1:0] exp);
        int lat;
        shift_xy(xv, yv);
        run_mul(sm, '0, 1'b0, lat);
        check({tag, "_lat"}, PW'(lat), PW'(14));
        check({tag, "_z"}, z_par, exp);
        check({tag, "_busy_off"}, PW'(busy), PW'(0));
    endtask

    initial begin
        int            lat, busy_cnt, done_cnt;
        logic [PW-1:0] zexp, zcap;

        // reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_z_par", z_par, '0);
        check("rst_flags", PW'({fx, fy, fz, done, busy, z_out}), PW'(0));
        check("rst_state", PW'(fsm_state), PW'(IDLE));
        rst = 1'b1;
        tick();

        // 5 * -3 signed
        do_product("s5xm3", 12'h005, 12'hFFD, 1'b1, 24'hFFFFF1);

        // unsigned 4093 * 5
        do_product("u4093x5", 12'hFFD, 12'h005, 1'b0, 24'h004FF1);

        // most negative squared, then serial readout
        do_product("s800sq", 12'h800, 12'h800, 1'b1, 24'h400000);
        zexp = 24'h400000;
        for (int i = 1; i <= PW; i++) begin
            sz = 1'b1;
            @(negedge clk);
            check($sformatf("zout_b%0d", i), PW'(z_out), PW'(zexp[PW-i]));
            check($sformatf("fz_b%0d", i), PW'(fz), PW'(i == PW));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("zout_after", PW'(z_out), PW'(0));
        check("fz_after", PW'(fz), PW'(0));
        @(posedge clk);
        #1;
        sz = 1'b0;

        // all-ones operands, both modes
        do_product("uFFFsq", 12'hFFF, 12'hFFF, 1'b0, 24'hFFE001);
        do_product("sFFFsq", 12'hFFF, 12'hFFF, 1'b1, 24'h000001);

        // second mul while busy is dropped
        shift_xy(12'h007, 12'h006);
        signed_mode = 1'b1;
        mul = 1'b1;
        tick();
        mul = 1'b0;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        zcap = '0;
        for (int c = 1; c <= 30; c++) begin
            mul = (c == 3);
            tick();
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                zcap = z_par;
            end
        end
        mul = 1'b0;
        check("ign_busy_cycles", PW'(busy_cnt), PW'(14));
        check("ign_done_count", PW'(done_cnt), PW'(1));
        check("ign_z", zcap, 24'h00002A);

        // reset in MULT iteration 5 aborts everything
        mul = 1'b1;
        tick();
        mul = 1'b0;
        repeat (6) tick();
        check("pre_rst_state", PW'(fsm_state), PW'(MULT));
        rst = 1'b0;
        #1;
        check("abort_z_par", z_par, '0);
        check("abort_flags", PW'({fx, fy, fz, done, busy, z_out}), PW'(0));
        check("abort_state", PW'(fsm_state), PW'(IDLE));
        tick();
        rst = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done) done_cnt++;
        end
        check("abort_no_done", PW'(done_cnt), PW'(0));
        do_product("s7xm7", 12'h007, 12'hFF9, 1'b1, 24'hFFFFCF);

        // new X bits streamed in during a product do not disturb it
        shift_xy(12'h003, 12'hFFE);
        run_mul(1'b1, 12'h7FF, 1'b1, lat);
        check("inflight_lat", PW'(lat), PW'(14));
        check("inflight_z", z_par, 24'hFFFFFA);
        // the streamed word is now the X operand: 2047 * -2
        run_mul(1'b1, '0, 1'b0, lat);
        check("newx_lat", PW'(lat), PW'(14));
        check("newx_z", z_par, 24'hFFF002);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
